// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared register map, CTRL bit positions and FSM encoding for dma
package dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_IEN   = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_BUSY  = 3;
    localparam int CTRL_ABORT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

endpackage

// File: rtl/dma.sv
// rtl/dma.sv - single-channel word-copy DMA: register responder plus bus initiator
module dma
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        wr,
    input  logic [3:2]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        irq,
    output logic        bus_en,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_data_in,
    output logic [31:0] bus_data_out,
    input  logic        bus_wt
);

    state_t      state_q, state_d;
    logic [29:0] src_q, dst_q;
    logic [15:0] cnt_q;
    logic [31:0] hold_q;
    logic        ien_q, done_q, busy_q, abort_q;

    logic reg_wr, ctrl_wr, start_req, launch, last_word, zero_done, finish;

    assign reg_wr    = en && wr;
    assign ctrl_wr   = reg_wr && (addr == REG_CTRL);
    assign start_req = ctrl_wr && data_in[CTRL_START] && !busy_q;
    // BUSY is set one edge before the FSM leaves IDLE; that cycle decides RD vs. empty completion.
    assign launch    = busy_q && (state_q == IDLE);
    assign zero_done = launch && (cnt_q == 16'd0);
    assign last_word = (state_q == WR) && !bus_wt && ((cnt_q == 16'd1) || abort_q);
    assign finish    = last_word || zero_done;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch && (cnt_q != 16'd0)) state_d = RD;
            RD:   if (!bus_wt) state_d = WR;
            WR:   if (!bus_wt) state_d = ((cnt_q == 16'd1) || abort_q) ? IDLE : RD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            ien_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (reg_wr && !busy_q) begin
                case (addr)
                    REG_SRC: src_q <= data_in[31:2];
                    REG_DST: dst_q <= data_in[31:2];
                    REG_CNT: cnt_q <= data_in[15:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) ien_q <= data_in[CTRL_IEN];

            if ((state_q == RD) && !bus_wt) hold_q <= bus_data_in;
            if ((state_q == WR) && !bus_wt) begin
                src_q <= src_q + 30'd1;
                dst_q <= dst_q + 30'd1;
                cnt_q <= cnt_q - 16'd1;
            end

            if (start_req)   busy_q <= 1'b1;
            else if (finish) busy_q <= 1'b0;

            // A completion on the same edge as a software clear must leave DONE set.
            if (finish)                                done_q <= 1'b1;
            else if (ctrl_wr && !data_in[CTRL_DONE])   done_q <= 1'b0;

            if (finish)                                         abort_q <= 1'b0;
            else if (ctrl_wr && data_in[CTRL_ABORT] && busy_q)  abort_q <= 1'b1;
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            REG_SRC:  data_out = {src_q, 2'b00};
            REG_DST:  data_out = {dst_q, 2'b00};
            REG_CNT:  data_out = {16'd0, cnt_q};
            REG_CTRL: data_out = {27'd0, 1'b0, busy_q, done_q, ien_q, 1'b0};
            default:  data_out = '0;
        endcase
    end

    // Initiator outputs decode only flopped state, so they stay put while bus_wt holds the cycle.
    assign bus_en       = (state_q != IDLE);
    assign bus_wr       = (state_q == WR);
    assign bus_size     = 2'b10;
    assign bus_addr     = (state_q == RD) ? {src_q, 2'b00} :
                          (state_q == WR) ? {dst_q, 2'b00} : 32'd0;
    assign bus_data_out = (state_q == WR) ? hold_q : 32'd0;
    assign wt           = 1'b0;
    assign irq          = done_q && ien_q;

endmodule

// File: tb/tb_dma.sv
// tb/tb_dma.sv - self-checking bench for dma: register vectors plus bus scoreboard
module tb_dma;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [3:2]  addr = 2'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        wt, irq, bus_en, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_data_out;
    logic [31:0] bus_data_in;
    logic        bus_wt;

    dma dut (
        .clk(clk), .reset_n(reset_n), .en(en), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .wt(wt), .irq(irq),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_wt(bus_wt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } bus_exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } reg_vec_t;

    bus_exp_t    sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        sb_off = 1'b0;
    logic [31:0] stall_addr = 32'd0;
    int          stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    task automatic push_word(input logic [31:0] s, input logic [31:0] d);
        bus_exp_t e;
        e.w = 1'b0; e.a = s; e.d = 32'd0;
        sb.push_back(e);
        e.w = 1'b1; e.a = d; e.d = pattern(s);
        sb.push_back(e);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        en = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b0; data_in = 32'd0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        en = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = data_out;
        en = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        logic [31:0] r;
        cyc = 0;
        r = 32'd0;
        while (!r[CTRL_DONE] && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            rd_reg(REG_CTRL, r);
        end
    endtask

    // Responder: answers at the negedge before each edge, optionally stalling one address.
    initial begin
        logic        held;
        logic        h_wr;
        logic [31:0] h_addr, h_dout;
        bus_exp_t    e;
        held = 1'b0; h_wr = 1'b0; h_addr = 32'd0; h_dout = 32'd0;
        bus_wt = 1'b0;
        bus_data_in = 32'd0;
        forever begin
            @(negedge clk);
            if (held) begin
                check("stall_bus_en", 32'(bus_en), 32'd1);
                check("stall_bus_wr", 32'(bus_wr), 32'(h_wr));
                check("stall_bus_addr", bus_addr, h_addr);
                check("stall_bus_data_out", bus_data_out, h_dout);
            end
            held = 1'b0;
            if (bus_en && !bus_wr && stall_left > 0 && bus_addr == stall_addr) begin
                bus_wt = 1'b1;
                bus_data_in = 32'hDEAD_BEEF;
                stall_left--;
                held = 1'b1; h_wr = bus_wr; h_addr = bus_addr; h_dout = bus_data_out;
            end else begin
                bus_wt = 1'b0;
                bus_data_in = pattern(bus_addr);
                if (bus_en && !sb_off) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_bus_cycle: got wr=%0d addr=0x%08h expected none", bus_wr, bus_addr);
                    end else begin
                        e = sb.pop_front();
                        check("bus_wr", 32'(bus_wr), 32'(e.w));
                        check("bus_addr", bus_addr, e.a);
                        if (e.w) check("bus_data_out", bus_data_out, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reg_vec_t    vecs[8];
        logic [31:0] r;
        int          cyc;
        logic        found;

        vecs[0] = '{1'b1, REG_SRC,  32'h1234_5677, 32'h1234_5674};
        vecs[1] = '{1'b1, REG_DST,  32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[2] = '{1'b1, REG_CNT,  32'hABCD_1234, 32'h0000_1234};
        vecs[3] = '{1'b1, REG_CTRL, 32'h0000_0002, 32'h0000_0002};
        vecs[4] = '{1'b1, REG_CTRL, 32'h0000_000E, 32'h0000_0002};
        vecs[5] = '{1'b1, REG_CTRL, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b0, REG_SRC,  32'h0000_0000, 32'h1234_5674};
        vecs[7] = '{1'b0, REG_CNT,  32'h0000_0000, 32'h0000_1234};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd_reg(REG_SRC, r);  check("reset_src", r, 32'd0);
        rd_reg(REG_DST, r);  check("reset_dst", r, 32'd0);
        rd_reg(REG_CNT, r);  check("reset_cnt", r, 32'd0);
        rd_reg(REG_CTRL, r); check("reset_ctrl", r, 32'd0);
        check("reset_bus_en", 32'(bus_en), 32'd0);
        check("reset_bus_wr", 32'(bus_wr), 32'd0);
        check("reset_bus_addr", bus_addr, 32'd0);
        check("reset_bus_data_out", bus_data_out, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("bus_size", 32'(bus_size), 32'd2);
        check("wt", 32'(wt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].w) wr_reg(vecs[i].a, vecs[i].d);
            rd_reg(vecs[i].a, r);
            check($sformatf("regvec%0d", i), r, vecs[i].exp);
        end

        // Basic 3-word copy, IEN=0
        wr_reg(REG_SRC, 32'h100); wr_reg(REG_DST, 32'h200); wr_reg(REG_CNT, 32'd3);
        for (int i = 0; i < 3; i++) push_word(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i));
        wr_reg(REG_CTRL, 32'h1);
        check("start_bus_en_low", 32'(bus_en), 32'd0);
        @(posedge clk); #1;
        check("bus_en_rise", 32'(bus_en), 32'd1);
        wait_done(cyc);
        check("latency_3w", 32'(cyc), 32'd6);
        check("irq_ien0", 32'(irq), 32'd0);
        rd_reg(REG_CNT, r); check("cnt_after_3w", r, 32'd0);
        rd_reg(REG_SRC, r); check("src_after_3w", r, 32'h10C);
        rd_reg(REG_DST, r); check("dst_after_3w", r, 32'h20C);
        check("sb_empty_3w", 32'(sb.size()), 32'd0);
        wr_reg(REG_CTRL, 32'h6);
        check("irq_ien1", 32'(irq), 32'd1);
        wr_reg(REG_CTRL, 32'h2);
        check("irq_done_clr", 32'(irq), 32'd0);
        rd_reg(REG_CTRL, r); check("ctrl_done_clr", r, 32'h2);

        // Three-cycle stall on the second read
        wr_reg(REG_SRC, 32'h100); wr_reg(REG_DST, 32'h200); wr_reg(REG_CNT, 32'd3);
        for (int i = 0; i < 3; i++) push_word(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i));
        stall_addr = 32'h104; stall_left = 3;
        wr_reg(REG_CTRL, 32'h3);
        @(posedge clk); #1;
        wait_done(cyc);
        check("latency_stall", 32'(cyc), 32'd9);
        check("stall_consumed", 32'(stall_left), 32'd0);
        check("irq_stall", 32'(irq), 32'd1);
        check("sb_empty_stall", 32'(sb.size()), 32'd0);
        wr_reg(REG_CTRL, 32'h0);

        // CNT=0: immediate completion, no bus cycle
        wr_reg(REG_CNT, 32'd0);
        wr_reg(REG_CTRL, 32'h1);
        rd_reg(REG_CTRL, r); check("cnt0_busy", r, 32'h8);
        check("cnt0_bus_en_a", 32'(bus_en), 32'd0);
        @(posedge clk); #1;
        rd_reg(REG_CTRL, r); check("cnt0_done", r, 32'h4);
        check("cnt0_bus_en_b", 32'(bus_en), 32'd0);
        wr_reg(REG_CTRL, 32'h0);

        // ABORT during the read of word 2
        wr_reg(REG_SRC, 32'h300); wr_reg(REG_DST, 32'h400); wr_reg(REG_CNT, 32'd5);
        push_word(32'h300, 32'h400);
        push_word(32'h304, 32'h404);
        wr_reg(REG_CTRL, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (bus_en && !bus_wr && bus_addr == 32'h304) found = 1'b1;
        end
        check("abort_rd2_seen", 32'(found), 32'd1);
        wr_reg(REG_CTRL, 32'h10);
        wait_done(cyc);
        rd_reg(REG_CNT, r);  check("abort_cnt", r, 32'd3);
        rd_reg(REG_SRC, r);  check("abort_src", r, 32'h308);
        rd_reg(REG_DST, r);  check("abort_dst", r, 32'h408);
        rd_reg(REG_CTRL, r); check("abort_ctrl", r, 32'h4);
        check("sb_empty_abort", 32'(sb.size()), 32'd0);
        wr_reg(REG_CTRL, 32'h0);

        // Source address wrap; a DST write while busy must be ignored
        wr_reg(REG_SRC, 32'hFFFF_FFFC); wr_reg(REG_DST, 32'h500); wr_reg(REG_CNT, 32'd2);
        push_word(32'hFFFF_FFFC, 32'h500);
        push_word(32'h0000_0000, 32'h504);
        wr_reg(REG_CTRL, 32'h1);
        wr_reg(REG_DST, 32'h999);
        wait_done(cyc);
        rd_reg(REG_SRC, r); check("wrap_src", r, 32'h4);
        rd_reg(REG_DST, r); check("wrap_dst", r, 32'h508);
        rd_reg(REG_CNT, r); check("wrap_cnt", r, 32'd0);
        check("sb_empty_wrap", 32'(sb.size()), 32'd0);

        // Reset pulse during WR
        wr_reg(REG_SRC, 32'h600); wr_reg(REG_DST, 32'h700); wr_reg(REG_CNT, 32'd4);
        wr_reg(REG_CTRL, 32'h7);
        check("irq_before_reset", 32'(irq), 32'd1);
        sb_off = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (bus_en && bus_wr) found = 1'b1;
        end
        check("reset_wr_seen", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_bus_en", 32'(bus_en), 32'd0);
        reset_n = 1'b1;
        rd_reg(REG_SRC, r);  check("rst_src", r, 32'd0);
        rd_reg(REG_DST, r);  check("rst_dst", r, 32'd0);
        rd_reg(REG_CNT, r);  check("rst_cnt", r, 32'd0);
        rd_reg(REG_CTRL, r); check("rst_ctrl", r, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_data_out", bus_data_out, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("rst_bus_en_stays", 32'(bus_en), 32'd0);
        sb.delete();
        sb_off = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dma.md
# dma

Single-channel memory-to-memory DMA controller for the ECO32 system bus. It is a responder on its register window, configured by the CPU through busctrl. It is also an initiator on a second port, with signals identical to the CPU bus port, that copies a block of 32-bit words from a source address to a destination address. It raises an interrupt on completion. Arbitration between the CPU and this initiator port is handled by a separate arbiter block.

## Interface
- No parameters.
- clk  in  1  system clock (the same clk that drives the cpu and devices)
- reset_n  in  1  reset: **one clock; reset is synchronous and active-low**, sampled on the rising edge of clk
- en  in  1  register-port select from busctrl
- wr  in  1  register-port write when 1, read when 0
- addr  in  [3:2]  register index: 0 SRC, 1 DST, 2 CNT, 3 CTRL
- data_in  in  32  register write data
- data_out  out  32  register read data (combinational from addr)
- wt  out  1  register-port wait; tied to 0
- irq  out  1  completion interrupt, wired to a spare cpu_irq line
- bus_en  out  1  initiator request
- bus_wr  out  1  initiator write when 1
- bus_size  out  2  always 2'b10 (word)
- bus_addr  out  32  initiator address; bits [1:0] always 0
- bus_data_in  in  32  read data returned to the initiator
- bus_data_out  out  32  write data from the initiator
- bus_wt  in  1  wait; a cycle completes on the clock edge where bus_en=1 and bus_wt=0

## Operation
- Registers:
  - SRC[31:2] and DST[31:2] are read/write; bits [1:0] read as 0.
  - CNT[15:0] is the number of words remaining; bits [31:16] read as 0.
  - CTRL bits:
    - bit0 START: write-only, reads 0.
    - bit1 IEN: read/write.
    - bit2 DONE: write 0 to clear; writing 1 has no effect.
    - bit3 BUSY: read-only.
    - bit4 ABORT: write-only, reads 0.
- While BUSY, writes to SRC, DST and CNT are ignored. A CTRL write while BUSY updates IEN and can request ABORT; START is ignored.
- Writing START=1 while idle sets BUSY.
  - If CNT=0, BUSY clears and DONE sets on the next edge. No bus cycle is issued.
- State machine:
  - IDLE → RD on START with CNT≠0.
  - RD: bus_en=1, bus_wr=0, bus_addr=SRC. On completion, latch bus_data_in into the holding register HOLD and go to WR.
  - WR: bus_en=1, bus_wr=1, bus_addr=DST, bus_data_out=HOLD. On completion:
    - SRC+=4 and DST+=4, both mod 2^32 (wrap silently past 0xFFFFFFFC).
    - CNT-=1.
    - If CNT was 1 or ABORT is pending, go to IDLE with DONE=1 and BUSY=0.
    - Otherwise go to RD.
- ABORT is latched as pending and takes effect only at the end of the current WR completion. A started word is never split, and bus_en is never dropped while the responder is waiting.
- After an abort, SRC, DST and CNT hold the values for the next untransferred word.
- irq = DONE & IEN.
- If a software DONE clear and hardware completion happen in the same cycle, the hardware set wins.

## Timing
- Reset values:
  - All registers, HOLD, DONE, BUSY, the pending-abort flag and the state are 0 / IDLE.
  - bus_en=0, bus_wr=0, bus_addr=0, bus_data_out=0, irq=0.
  - bus_size=2'b10 at all times.
- All initiator outputs are registered from state.
- bus_en rises on the first edge after the START write edge.
- With bus_wt=0 throughout, each word takes 2 cycles (RD, WR). N words take 2N cycles from bus_en rising until DONE is visible.
- While bus_wt=1, bus_en, bus_wr, bus_addr and bus_data_out are held stable.
- The register port has zero wait states. data_out reflects register contents in the same cycle.
- reset_n=0 mid-transfer: the block returns to IDLE on that edge with bus_en=0. No completion is recorded.

## Structure
- Shared package/header holds:
  - register indices REG_SRC, REG_DST, REG_CNT, REG_CTRL;
  - CTRL bit positions;
  - the state encoding IDLE, RD, WR.
- Single module. The register file and FSM are small enough that no sub-module is warranted.

## Test plan
- SRC=0x100, DST=0x200, CNT=3, START with bus_wt=0:
  - reads at 0x100, 0x104, 0x108 each followed by writes at 0x200, 0x204, 0x208 with the matching data;
  - DONE=1 after 6 cycles; CNT reads 0, SRC reads 0x10C;
  - irq=1 only if IEN=1.
- Responder holds bus_wt=1 for 3 cycles on the second read:
  - address and control stay stable;
  - HOLD is latched only on the bus_wt=0 edge;
  - total latency becomes 9 cycles.
- CNT=0 with START: DONE sets on the next cycle; bus_en is never asserted.
- CNT=5, ABORT written during the RD of word 2:
  - word 2 still completes its write, then IDLE with DONE=1;
  - CNT=3, SRC=base+8.
- SRC=0xFFFFFFFC, CNT=2: the second read address is 0x00000000.
- reset_n pulsed low during WR: bus_en=0 on the next edge; all registers read 0; irq=0.
